// File: rtl/pq_pkg.sv
// Shared types for the sorted priority-queue path: slot element layout,
// per-slot shift control and the occupancy-counter width helper.
package pq_pkg;

    localparam int PQ_KEY_W = 32;
    localparam int PQ_VAL_W = 32;
    localparam int PQ_DEPTH = 16;

    typedef struct packed {
        logic                valid;
        logic [PQ_KEY_W-1:0] key;
        logic [PQ_VAL_W-1:0] val;
    } pq_elem_t;

    typedef enum logic [1:0] {
        SHIFT_HOLD = 2'd0,
        SHIFT_UP   = 2'd1,
        SHIFT_DOWN = 2'd2,
        SHIFT_LOAD = 2'd3
    } pq_shift_e;

    // Width needed to count 0..depth inclusive.
    function automatic int clog2_depth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pq_slot.sv
// One storage slot of the systolic sorted array. It compares its own key with
// the incoming key and picks hold / take-below / take-above / load-new locally.
module pq_slot
    import pq_pkg::*;
#(
    parameter int KEY_W    = PQ_KEY_W,
    parameter int VAL_W    = PQ_VAL_W,
    parameter bit IS_FIRST = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_fire,
    input  logic                   pop_fire,
    input  logic [KEY_W-1:0]       push_key,
    input  logic [VAL_W-1:0]       push_val,
    input  logic [KEY_W+VAL_W:0]   below_elem,
    input  logic [KEY_W+VAL_W:0]   above_elem,
    input  logic                   gt_below,
    input  logic                   gt_above,
    output logic [KEY_W+VAL_W:0]   elem,
    output logic                   gt
);

    typedef struct packed {
        logic             valid;
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] val;
    } slot_elem_t;

    slot_elem_t cur_r;
    slot_elem_t nxt_s;
    slot_elem_t below_s;
    slot_elem_t above_s;
    slot_elem_t push_s;
    pq_shift_e  shift_s;

    assign below_s = below_elem;
    assign above_s = above_elem;
    assign push_s  = '{valid: 1'b1, key: push_key, val: push_val};
    assign elem    = cur_r;

    // An empty slot counts as "greater", so the first free slot is the insert point.
    assign gt = ~cur_r.valid | (cur_r.key > push_key);

    // Local shift decision from this slot's flag and its neighbours' flags.
    always_comb begin
        shift_s = SHIFT_HOLD;
        if (push_fire && pop_fire) begin
            // Replace: old slot[0] leaves, the new key joins the remaining set.
            if (!gt_above) begin
                shift_s = SHIFT_DOWN;
            end else if (IS_FIRST || !gt) begin
                shift_s = SHIFT_LOAD;
            end else begin
                shift_s = SHIFT_HOLD;
            end
        end else if (push_fire) begin
            if (gt && gt_below) begin
                shift_s = SHIFT_UP;
            end else if (gt) begin
                shift_s = SHIFT_LOAD;
            end else begin
                shift_s = SHIFT_HOLD;
            end
        end else if (pop_fire) begin
            shift_s = SHIFT_DOWN;
        end else begin
            shift_s = SHIFT_HOLD;
        end
    end

    // Next-element multiplexer.
    always_comb begin
        nxt_s = cur_r;
        case (shift_s)
            SHIFT_HOLD: nxt_s = cur_r;
            SHIFT_UP:   nxt_s = below_s;
            SHIFT_DOWN: nxt_s = above_s;
            SHIFT_LOAD: nxt_s = push_s;
            default:    nxt_s = cur_r;
        endcase
    end

    // Slot storage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_r <= '0;
        end else begin
            cur_r <= nxt_s;
        end
    end

endmodule

// File: rtl/pq_sorted_path.sv
// Sorted priority-queue path: DEPTH-entry systolic array kept ascending by key.
// Define PQ_REPLACE_EN to accept a simultaneous push and pop in one cycle.
module pq_sorted_path
    import pq_pkg::*;
#(
    parameter int KEY_W = PQ_KEY_W,
    parameter int VAL_W = PQ_VAL_W,
    parameter int DEPTH = PQ_DEPTH
) (
    input  logic                         system1000,
    input  logic                         system1000_rst,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [KEY_W-1:0]             push_key,
    input  logic [VAL_W-1:0]             push_val,
    input  logic                         pop_valid,
    output logic                         pop_ready,
    output logic                         out_valid,
    output logic [KEY_W-1:0]             out_key,
    output logic [VAL_W-1:0]             out_val,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int EW    = 1 + KEY_W + VAL_W;
    localparam int CNT_W = clog2_depth(DEPTH);

    logic [EW-1:0]    elem_s [DEPTH];
    logic             gt_s   [DEPTH];
    logic             push_fire_s;
    logic             pop_fire_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    assign pop_ready = ~empty;
`ifdef PQ_REPLACE_EN
    assign push_ready = ~full | pop_valid;
`else
    assign push_ready = ~full & ~pop_valid;
`endif
    assign push_fire_s = push_valid & push_ready;
    assign pop_fire_s  = pop_valid & pop_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [EW-1:0] below_s;
        logic [EW-1:0] above_s;
        logic          gt_below_s;
        logic          gt_above_s;

        if (i == 0) begin : g_lo
            assign below_s    = '0;
            assign gt_below_s = 1'b0;
        end else begin : g_lo
            assign below_s    = elem_s[i-1];
            assign gt_below_s = gt_s[i-1];
        end

        // Beyond the top slot the array looks empty: invalid and "greater".
        if (i == DEPTH - 1) begin : g_hi
            assign above_s    = '0;
            assign gt_above_s = 1'b1;
        end else begin : g_hi
            assign above_s    = elem_s[i+1];
            assign gt_above_s = gt_s[i+1];
        end

        pq_slot #(
            .KEY_W    (KEY_W),
            .VAL_W    (VAL_W),
            .IS_FIRST (i == 0)
        ) u_slot (
            .clk        (system1000),
            .rst        (system1000_rst),
            .push_fire  (push_fire_s),
            .pop_fire   (pop_fire_s),
            .push_key   (push_key),
            .push_val   (push_val),
            .below_elem (below_s),
            .above_elem (above_s),
            .gt_below   (gt_below_s),
            .gt_above   (gt_above_s),
            .elem       (elem_s[i]),
            .gt         (gt_s[i])
        );
    end

    // Occupancy after this cycle's accepted operations.
    always_comb begin
        cnt_nxt_s = count;
        if (push_fire_s && !pop_fire_s) begin
            cnt_nxt_s = count + CNT_W'(1'b1);
        end else if (pop_fire_s && !push_fire_s) begin
            cnt_nxt_s = count - CNT_W'(1'b1);
        end else begin
            cnt_nxt_s = count;
        end
    end

    // Status and popped-entry output registers.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            out_valid <= 1'b0;
            out_key   <= '0;
            out_val   <= '0;
        end else begin
            count     <= cnt_nxt_s;
            empty     <= (cnt_nxt_s == CNT_W'(0));
            full      <= (cnt_nxt_s == CNT_W'(DEPTH));
            out_valid <= pop_fire_s;
            if (pop_fire_s) begin
                out_key <= elem_s[0][KEY_W+VAL_W-1:VAL_W];
                out_val <= elem_s[0][VAL_W-1:0];
            end else begin
                out_key <= out_key;
                out_val <= out_val;
            end
        end
    end

endmodule

// File: tb/tb_pq_sorted_path.sv
// Directed self-checking bench for pq_sorted_path (default 32/32/16 build).
module tb_pq_sorted_path;

    localparam int KEY_W = 32;
    localparam int VAL_W = 32;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             system1000 = 1'b0;
    logic             system1000_rst;
    logic             push_valid;
    logic             push_ready;
    logic [KEY_W-1:0] push_key;
    logic [VAL_W-1:0] push_val;
    logic             pop_valid;
    logic             pop_ready;
    logic             out_valid;
    logic [KEY_W-1:0] out_key;
    logic [VAL_W-1:0] out_val;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;

    int n_checks = 0;
    int n_errors = 0;

    pq_sorted_path #(.KEY_W(KEY_W), .VAL_W(VAL_W), .DEPTH(DEPTH)) dut (
        .system1000     (system1000),
        .system1000_rst (system1000_rst),
        .push_valid     (push_valid),
        .push_ready     (push_ready),
        .push_key       (push_key),
        .push_val       (push_val),
        .pop_valid      (pop_valid),
        .pop_ready      (pop_ready),
        .out_valid      (out_valid),
        .out_key        (out_key),
        .out_val        (out_val),
        .count          (count),
        .empty          (empty),
        .full           (full)
    );

    always #5 system1000 = ~system1000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge system1000);
        #1;
    endtask

    task automatic push(input logic [31:0] k, input logic [31:0] v);
        push_valid = 1'b1;
        push_key   = k;
        push_val   = v;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] k, input logic [31:0] v);
        pop_valid = 1'b1;
        tick();
        pop_valid = 1'b0;
        check({tag, "_ovalid"}, 32'(out_valid), 32'd1);
        check({tag, "_okey"}, out_key, k);
        check({tag, "_oval"}, out_val, v);
    endtask

    initial begin
        system1000_rst = 1'b1;
        push_valid = 1'b0;
        push_key   = 32'd0;
        push_val   = 32'd0;
        pop_valid  = 1'b0;
        tick();
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovalid", 32'(out_valid), 32'd0);
        check("rst_okey", out_key, 32'd0);
        check("rst_oval", out_val, 32'd0);
        system1000_rst = 1'b0;
        #1;
        check("rst_pop_ready", 32'(pop_ready), 32'd0);

        // Sorted insertion and ascending drain.
        push(32'd5, 32'd105);
        push(32'd3, 32'd103);
        push(32'd9, 32'd109);
        push(32'd1, 32'd101);
        check("sort_count", 32'(count), 32'd4);
        pop_chk("sort_p0", 32'd1, 32'd101);
        pop_chk("sort_p1", 32'd3, 32'd103);
        pop_chk("sort_p2", 32'd5, 32'd105);
        pop_chk("sort_p3", 32'd9, 32'd109);
        check("sort_empty", 32'(empty), 32'd1);
        tick();
        check("hold_ovalid", 32'(out_valid), 32'd0);
        check("hold_okey", out_key, 32'd9);

        // Equal keys leave in arrival order.
        push(32'd7, 32'd1);
        push(32'd7, 32'd2);
        push(32'd7, 32'd3);
        pop_chk("tie_p0", 32'd7, 32'd1);
        pop_chk("tie_p1", 32'd7, 32'd2);
        pop_chk("tie_p2", 32'd7, 32'd3);

        // Fill, then a held 17th push with the largest key.
        for (int i = 0; i < DEPTH; i++) push(32'(i), 32'(i + 200));
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd16);
        push_valid = 1'b1;
        push_key   = 32'hFFFF_FFFF;
        push_val   = 32'd77;
        #1;
        check("fill_push_ready", 32'(push_ready), 32'd0);
        tick();
        tick();
        check("fill_held_count", 32'(count), 32'd16);
        pop_valid = 1'b1;
        tick();
        pop_valid = 1'b0;
        check("fill_pop_okey", out_key, 32'd0);
`ifndef PQ_REPLACE_EN
        check("fill_mid_count", 32'(count), 32'd15);
        tick();
`endif
        push_valid = 1'b0;
        check("fill_after_count", 32'(count), 32'd16);
        check("fill_after_full", 32'(full), 32'd1);
        for (int i = 1; i < DEPTH; i++) pop_chk($sformatf("drain_%0d", i), 32'(i), 32'(i + 200));
        pop_chk("drain_last", 32'hFFFF_FFFF, 32'd77);
        check("drain_empty", 32'(empty), 32'd1);

        // Pop requests on an empty queue are ignored.
        pop_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("epop_ready", 32'(pop_ready), 32'd0);
            tick();
            check("epop_ovalid", 32'(out_valid), 32'd0);
            check("epop_count", 32'(count), 32'd0);
        end
        pop_valid = 1'b0;

        // Simultaneous push 1 / pop on {2, 4}.
        push(32'd2, 32'd52);
        push(32'd4, 32'd54);
        push_valid = 1'b1;
        push_key   = 32'd1;
        push_val   = 32'd51;
        pop_valid  = 1'b1;
        #1;
`ifdef PQ_REPLACE_EN
        check("rep_push_ready", 32'(push_ready), 32'd1);
        tick();
        push_valid = 1'b0;
        pop_valid  = 1'b0;
        check("rep_okey", out_key, 32'd2);
        check("rep_count", 32'(count), 32'd2);
`else
        check("rep_push_ready", 32'(push_ready), 32'd0);
        tick();
        pop_valid = 1'b0;
        check("rep_okey", out_key, 32'd2);
        check("rep_count_mid", 32'(count), 32'd1);
        tick();
        push_valid = 1'b0;
        check("rep_count", 32'(count), 32'd2);
`endif
        pop_chk("rep_p0", 32'd1, 32'd51);
        pop_chk("rep_p1", 32'd4, 32'd54);

        // Reset mid-stream discards contents and an in-flight pop.
        for (int i = 0; i < 5; i++) push(32'(i + 10), 32'(i));
        check("mid_count_pre", 32'(count), 32'd5);
        system1000_rst = 1'b1;
        pop_valid = 1'b1;
        tick();
        system1000_rst = 1'b0;
        pop_valid = 1'b0;
        check("mid_count", 32'(count), 32'd0);
        check("mid_empty", 32'(empty), 32'd1);
        check("mid_ovalid", 32'(out_valid), 32'd0);
        push(32'd8, 32'd88);
        pop_chk("mid_p0", 32'd8, 32'd88);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
